// File: rtl/ahb_sram_slave.sv
// AHB-style single-port SRAM responder with one decoded address window.
// Handles pipelined address/data phases, byte/halfword/word accesses,
// a fixed number of wait states per OKAY transfer and a two-cycle ERROR
// response for misaligned, oversized or out-of-window accesses.
//
// Ports:
//   clk_i     clock
//   resetn_i  synchronous active-low reset
//   hsel_i    select / transfer valid for the current address phase
//   haddr_i   byte address (address phase)
//   hwrite_i  1=write, 0=read (address phase)
//   hsize_i   000 byte, 001 halfword, 010 word (address phase)
//   hwdata_i  write data (data phase)
//   hrdata_o  read data, registered at address acceptance
//   hready_o  data phase completes this cycle / slave accepts an address
//   hresp_o   00 OKAY, 01 ERROR
module ahb_sram_slave #(
  parameter int unsigned            DATA_WIDTH  = 32,
  parameter int unsigned            ADDR_WIDTH  = 32,
  parameter int unsigned            MEM_DEPTH   = 1024,
  parameter logic [ADDR_WIDTH-1:0]  BASE_ADDR   = '0,
  parameter int unsigned            WAIT_STATES = 0
) (
  input  logic                  clk_i,
  input  logic                  resetn_i,
  input  logic                  hsel_i,
  input  logic [ADDR_WIDTH-1:0] haddr_i,
  input  logic                  hwrite_i,
  input  logic [2:0]            hsize_i,
  input  logic [DATA_WIDTH-1:0] hwdata_i,
  output logic [DATA_WIDTH-1:0] hrdata_o,
  output logic                  hready_o,
  output logic [1:0]            hresp_o
);

  localparam int unsigned IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam int unsigned CNT_W = 4;
  localparam int unsigned LANES = 4;
  localparam logic [ADDR_WIDTH-1:0] MEM_BYTES = ADDR_WIDTH'(MEM_DEPTH * 4);
  localparam logic [CNT_W-1:0] CNT_LOAD =
    CNT_W'((WAIT_STATES > 0) ? (WAIT_STATES - 1) : 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_DATA,
    S_ERR1,
    S_ERR2
  } state_t;

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    hready_d;
  logic [1:0]              hresp_d;

  // Attributes of the transfer currently in its data phase
  logic                    wr_q;
  logic [1:0]              size_q;
  logic [1:0]              lane_q;
  logic [IDX_W-1:0]        idx_q;

  logic [DATA_WIDTH-1:0]   mem [MEM_DEPTH];

  logic [ADDR_WIDTH-1:0]   offset_c;
  logic                    illegal_c;
  logic [IDX_W-1:0]        acc_idx_c;
  logic                    take_c;
  logic                    commit_c;
  logic [LANES-1:0]        be_c;
  logic [DATA_WIDTH-1:0]   merged_c;
  logic [DATA_WIDTH-1:0]   rd_word_c;

  // Address decode and legality of the address phase on the bus
  always_comb begin
    offset_c  = haddr_i - BASE_ADDR;
    acc_idx_c = offset_c[IDX_W+1:2];
    // Unsigned compare also rejects addresses below BASE_ADDR (they wrap high)
    illegal_c = (hsize_i > 3'b010)
              | ((hsize_i == 3'b001) & haddr_i[0])
              | ((hsize_i == 3'b010) & (haddr_i[1:0] != 2'b00))
              | (offset_c >= MEM_BYTES);
  end

  // Byte-enable merge of the pending write over the stored word
  always_comb begin
    be_c = '0;
    unique case (size_q)
      2'b00:   be_c = LANES'(4'b0001 << lane_q);
      2'b01:   be_c = lane_q[1] ? 4'b1100 : 4'b0011;
      default: be_c = 4'b1111;
    endcase
    merged_c = mem[idx_q];
    for (int n = 0; n < LANES; n++) begin
      if (be_c[n]) merged_c[8*n +: 8] = hwdata_i[8*n +: 8];
    end
  end

  assign commit_c = (state_q == S_DATA) & wr_q;

  // A read accepted in the same edge as a write commit to that word sees the merged word
  assign rd_word_c = (commit_c && (idx_q == acc_idx_c)) ? merged_c : mem[acc_idx_c];

  // Next-state and next-output logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    take_c  = 1'b0;
    unique case (state_q)
      S_WAIT: begin
        if (cnt_q == '0) state_d = S_DATA;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      S_ERR1: state_d = S_ERR2;
      default: begin
        // IDLE, DATA and ERR2 all drive hready_o high, so hsel_i alone means acceptance
        state_d = S_IDLE;
        if (hsel_i) begin
          if (illegal_c) begin
            state_d = S_ERR1;
          end else begin
            take_c  = 1'b1;
            state_d = (WAIT_STATES > 0) ? S_WAIT : S_DATA;
            cnt_d   = CNT_LOAD;
          end
        end
      end
    endcase
    hready_d = (state_d == S_IDLE) | (state_d == S_DATA) | (state_d == S_ERR2);
    hresp_d  = ((state_d == S_ERR1) | (state_d == S_ERR2)) ? 2'b01 : 2'b00;
  end

  // State, response and read-data registers
  always_ff @(posedge clk_i) begin
    if (!resetn_i) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      hready_o <= 1'b1;
      hresp_o  <= 2'b00;
      hrdata_o <= '0;
      wr_q     <= 1'b0;
      size_q   <= '0;
      lane_q   <= '0;
      idx_q    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hready_o <= hready_d;
      hresp_o  <= hresp_d;
      if (take_c) begin
        wr_q   <= hwrite_i;
        size_q <= hsize_i[1:0];
        lane_q <= haddr_i[1:0];
        idx_q  <= acc_idx_c;
        if (!hwrite_i) hrdata_o <= rd_word_c;
      end
    end
  end

  // Array write; a reset in the commit cycle drops the pending write entirely
  always_ff @(posedge clk_i) begin
    if (resetn_i && commit_c) mem[idx_q] <= merged_c;
  end

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Bench for ahb_sram_slave: four instances with different window/wait-state
// settings share one bus, each with its own select. A transaction-level
// model predicts hready/hresp/hrdata every cycle; literal checks pin results.
module tb_ahb_sram_slave;

  localparam int NK = 4;

  logic        clk_i = 1'b0;
  logic        resetn_i;
  logic [3:0]  hsel;
  logic [31:0] haddr_i;
  logic        hwrite_i;
  logic [2:0]  hsize_i;
  logic [31:0] hwdata_i;

  logic [31:0] rdata [NK];
  logic        rdy   [NK];
  logic [1:0]  resp  [NK];

  int checks   = 0;
  int failures = 0;
  int lowcnt [NK];

  always #5 clk_i = ~clk_i;

  ahb_sram_slave #(.MEM_DEPTH(64), .BASE_ADDR(32'h0),    .WAIT_STATES(0)) u_k0 (
    .clk_i(clk_i), .resetn_i(resetn_i), .hsel_i(hsel[0]), .haddr_i(haddr_i),
    .hwrite_i(hwrite_i), .hsize_i(hsize_i), .hwdata_i(hwdata_i),
    .hrdata_o(rdata[0]), .hready_o(rdy[0]), .hresp_o(resp[0]));
  ahb_sram_slave #(.MEM_DEPTH(64), .BASE_ADDR(32'h1000), .WAIT_STATES(0)) u_k1 (
    .clk_i(clk_i), .resetn_i(resetn_i), .hsel_i(hsel[1]), .haddr_i(haddr_i),
    .hwrite_i(hwrite_i), .hsize_i(hsize_i), .hwdata_i(hwdata_i),
    .hrdata_o(rdata[1]), .hready_o(rdy[1]), .hresp_o(resp[1]));
  ahb_sram_slave #(.MEM_DEPTH(64), .BASE_ADDR(32'h0),    .WAIT_STATES(2)) u_k2 (
    .clk_i(clk_i), .resetn_i(resetn_i), .hsel_i(hsel[2]), .haddr_i(haddr_i),
    .hwrite_i(hwrite_i), .hsize_i(hsize_i), .hwdata_i(hwdata_i),
    .hrdata_o(rdata[2]), .hready_o(rdy[2]), .hresp_o(resp[2]));
  ahb_sram_slave #(.MEM_DEPTH(64), .BASE_ADDR(32'h0),    .WAIT_STATES(3)) u_k3 (
    .clk_i(clk_i), .resetn_i(resetn_i), .hsel_i(hsel[3]), .haddr_i(haddr_i),
    .hwrite_i(hwrite_i), .hsize_i(hsize_i), .hwdata_i(hwdata_i),
    .hrdata_o(rdata[3]), .hready_o(rdy[3]), .hresp_o(resp[3]));

  function automatic int ws_of(input int k);
    case (k)
      2:       return 2;
      3:       return 3;
      default: return 0;
    endcase
  endfunction

  function automatic logic [31:0] base_of(input int k);
    return (k == 1) ? 32'h1000 : 32'h0;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  // ---------------- transaction-level model ----------------
  logic        m_ready [NK];
  logic [1:0]  m_resp  [NK];
  logic [31:0] m_rdata [NK];
  int          m_kind  [NK];   // 0 none, 1 OKAY transfer, 2 ERROR transfer
  int          m_lo    [NK];   // ready-low cycles still to come
  bit          m_wr    [NK];
  logic [31:0] m_addr  [NK];
  logic [2:0]  m_size  [NK];
  logic [31:0] mm      [NK][64];
  bit          chk_en = 1'b0;

  function automatic bit m_legal(input int k, input logic [31:0] a, input logic [2:0] sz);
    logic [31:0] off;
    off = a - base_of(k);
    if (sz > 3'd2) return 1'b0;
    if (sz == 3'd1 && a[0]) return 1'b0;
    if (sz == 3'd2 && a[1:0] != 2'b00) return 1'b0;
    return off < 32'd256;
  endfunction

  task automatic m_commit(input int k, input logic [31:0] a, input logic [2:0] sz,
                          input logic [31:0] d);
    int idx;
    bit hit;
    idx = int'((a - base_of(k)) >> 2);
    for (int n = 0; n < 4; n++) begin
      hit = (sz == 3'd2) || (sz == 3'd0 && n == int'(a[1:0])) ||
            (sz == 3'd1 && (n >> 1) == int'(a[1]));
      if (hit) mm[k][idx][8*n +: 8] = d[8*n +: 8];
    end
  endtask

  always @(posedge clk_i) begin
    for (int k = 0; k < NK; k++) begin
      if (!resetn_i) begin
        m_ready[k] = 1'b1; m_resp[k] = 2'b00; m_rdata[k] = 32'h0;
        m_kind[k] = 0; m_lo[k] = 0; m_wr[k] = 1'b0;
      end else if (m_ready[k]) begin
        if (m_kind[k] == 1 && m_wr[k]) m_commit(k, m_addr[k], m_size[k], hwdata_i);
        m_kind[k] = 0;
        m_resp[k] = 2'b00;
        if (hsel[k]) begin
          if (m_legal(k, haddr_i, hsize_i)) begin
            m_kind[k] = 1; m_wr[k] = hwrite_i; m_addr[k] = haddr_i; m_size[k] = hsize_i;
            if (!hwrite_i) m_rdata[k] = mm[k][int'((haddr_i - base_of(k)) >> 2)];
            m_lo[k] = ws_of(k);
            if (m_lo[k] > 0) begin m_ready[k] = 1'b0; m_lo[k]--; end
          end else begin
            m_kind[k] = 2; m_ready[k] = 1'b0; m_resp[k] = 2'b01;
          end
        end
      end else begin
        if (m_kind[k] == 2)  m_ready[k] = 1'b1;
        else if (m_lo[k] > 0) m_lo[k]--;
        else                 m_ready[k] = 1'b1;
      end
    end
    chk_en = 1'b1;
  end

  // Per-cycle compare of every instance against the model
  always @(negedge clk_i) begin
    if (chk_en) begin
      for (int k = 0; k < NK; k++) begin
        chk($sformatf("k%0d_hready", k), 32'(rdy[k]),  32'(m_ready[k]));
        chk($sformatf("k%0d_hresp", k),  32'(resp[k]), 32'(m_resp[k]));
        chk($sformatf("k%0d_hrdata", k), rdata[k],     m_rdata[k]);
        if (rdy[k] === 1'b0) lowcnt[k]++;
      end
    end
  end

  // ---------------- pipelined bus driver ----------------
  localparam int OP_XFER = 0;
  localparam int OP_RST  = 1;

  typedef struct {
    int          kind;
    int          k;
    bit          wr;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [31:0] wdata;
  } op_t;

  op_t opq [$];

  task automatic push(input int kind, input int k, input bit wr, input logic [31:0] addr,
                      input logic [2:0] size, input logic [31:0] wdata);
    op_t o;
    o.kind = kind; o.k = k; o.wr = wr; o.addr = addr; o.size = size; o.wdata = wdata;
    opq.push_back(o);
  endtask

  task automatic run_ops(output int ncyc);
    op_t dp;
    op_t nxt;
    bit  dp_v = 1'b0;
    bit  nxt_v;
    ncyc = 0;
    dp = '{default: 0};
    while ((opq.size() != 0 || dp_v) && ncyc < 500) begin
      resetn_i = 1'b1;
      hsel     = 4'b0000;
      hwdata_i = 32'h5A5A_A5A5;
      if (dp_v && dp.wr) hwdata_i = dp.wdata;
      nxt   = dp;
      nxt_v = dp_v && !m_ready[dp.k];
      if (opq.size() != 0) begin
        if (opq[0].kind == OP_RST) begin
          resetn_i = 1'b0;
          nxt_v    = 1'b0;
          void'(opq.pop_front());
        end else begin
          haddr_i  = opq[0].addr;
          hwrite_i = opq[0].wr;
          hsize_i  = opq[0].size;
          hsel[opq[0].k] = 1'b1;
          if (m_ready[opq[0].k]) begin
            nxt   = opq.pop_front();
            nxt_v = 1'b1;
          end
        end
      end
      dp   = nxt;
      dp_v = nxt_v;
      ncyc++;
      @(negedge clk_i);
    end
    if (ncyc >= 500) chk("run_ops_timeout", 32'(ncyc), 32'd0);
    resetn_i = 1'b1;
    hsel     = 4'b0000;
  endtask

  // ---------------- directed tests ----------------
  int n;

  initial begin
    for (int k = 0; k < NK; k++) lowcnt[k] = 0;
    resetn_i = 1'b0; hsel = 4'b0000; haddr_i = '0; hwrite_i = 1'b0;
    hsize_i = 3'b000; hwdata_i = '0;
    repeat (2) @(negedge clk_i);
    chk("reset_hready", 32'(rdy[0]), 32'd1);
    chk("reset_hresp",  32'(resp[0]), 32'd0);
    chk("reset_hrdata", rdata[0], 32'h0);
    resetn_i = 1'b1;

    // Back-to-back write then read of the same word, no wait states
    push(OP_XFER, 0, 1'b1, 32'h10, 3'b010, 32'hDEADBEEF);
    push(OP_XFER, 0, 1'b0, 32'h10, 3'b010, 32'h0);
    run_ops(n);
    chk("t1_cycles", 32'(n), 32'd3);
    chk("t1_rdata",  rdata[0], 32'hDEADBEEF);
    chk("t1_nolow",  32'(lowcnt[0]), 32'd0);

    // Sub-word writes with junk in the unselected lanes
    push(OP_XFER, 0, 1'b1, 32'h20, 3'b000, 32'hEEEEEE11);
    push(OP_XFER, 0, 1'b1, 32'h21, 3'b000, 32'hEEEE22EE);
    push(OP_XFER, 0, 1'b1, 32'h22, 3'b001, 32'h4433EEEE);
    push(OP_XFER, 0, 1'b0, 32'h20, 3'b010, 32'h0);
    run_ops(n);
    chk("t2_rdata", rdata[0], 32'h44332211);

    // Illegal accesses: misaligned word read, misaligned halfword write, bad size
    push(OP_XFER, 0, 1'b1, 32'h04, 3'b010, 32'h0BADF00D);
    push(OP_XFER, 0, 1'b0, 32'h02, 3'b010, 32'h0);
    push(OP_XFER, 0, 1'b1, 32'h05, 3'b001, 32'hFFFFFFFF);
    push(OP_XFER, 0, 1'b0, 32'h00, 3'b011, 32'h0);
    push(OP_XFER, 0, 1'b0, 32'h04, 3'b010, 32'h0);
    run_ops(n);
    chk("t3_rdata", rdata[0], 32'h0BADF00D);
    chk("t3_errlow", 32'(lowcnt[0]), 32'd3);

    // Window edges with BASE_ADDR=0x1000
    push(OP_XFER, 1, 1'b0, 32'h1100, 3'b010, 32'h0);
    push(OP_XFER, 1, 1'b0, 32'h0FFC, 3'b010, 32'h0);
    push(OP_XFER, 1, 1'b1, 32'h10FC, 3'b010, 32'hA5A50001);
    push(OP_XFER, 1, 1'b0, 32'h10FC, 3'b010, 32'h0);
    run_ops(n);
    chk("t4_rdata", rdata[1], 32'hA5A50001);
    chk("t4_errlow", 32'(lowcnt[1]), 32'd2);

    // Two wait states: one transfer per three cycles
    push(OP_XFER, 2, 1'b1, 32'h00, 3'b010, 32'h01010101);
    push(OP_XFER, 2, 1'b1, 32'h04, 3'b010, 32'h02020202);
    push(OP_XFER, 2, 1'b1, 32'h08, 3'b010, 32'h03030303);
    push(OP_XFER, 2, 1'b0, 32'h04, 3'b010, 32'h0);
    run_ops(n);
    chk("t5_cycles", 32'(n), 32'd13);
    chk("t5_rdata",  rdata[2], 32'h02020202);
    chk("t5_low",    32'(lowcnt[2]), 32'd8);

    // Reset during the wait of a second write must drop it
    push(OP_XFER, 3, 1'b1, 32'h40, 3'b010, 32'h12345678);
    push(OP_XFER, 3, 1'b1, 32'h40, 3'b010, 32'hCAFEF00D);
    push(OP_RST,  3, 1'b0, 32'h0,  3'b000, 32'h0);
    run_ops(n);
    chk("t6_rst_hready", 32'(rdy[3]),  32'd1);
    chk("t6_rst_hresp",  32'(resp[3]), 32'd0);
    chk("t6_rst_hrdata", rdata[3], 32'h0);
    chk("t6_low_before", 32'(lowcnt[3]), 32'd4);
    push(OP_XFER, 3, 1'b0, 32'h40, 3'b010, 32'h0);
    run_ops(n);
    chk("t6_rdata", rdata[3], 32'h12345678);
    chk("t6_low_after", 32'(lowcnt[3]), 32'd7);

    @(negedge clk_i);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
